// File: rtl/ram_ctl_if.sv
// ----------------------------------------------------------------------------
// ram_ctl_if -- bus bundle between the FSB stage and the DRAM/ROM controller.
//
// Signals
//   BACT    FSB -> ctl  bus cycle active
//   AINACT  FSB -> ctl  end-of-cycle strobe
//   RAMCS   FSB -> ctl  decoded RAM select, stable while BACT=1
//   ROMCS   FSB -> ctl  decoded ROM select, stable while BACT=1
//   Ready   ctl -> FSB  access may complete (feeds DTACK generation)
//   nRAS    ctl -> DRAM row strobe, active low
//   nCAS    ctl -> DRAM column strobe, active low
//   RASEL   ctl -> mux  address mux select, 1=row 0=column
//
// Modports
//   master  the FSB side (drives the request signals)
//   slave   the controller (drives Ready and the DRAM strobes)
// ----------------------------------------------------------------------------
interface ram_ctl_if;
    logic BACT;
    logic AINACT;
    logic RAMCS;
    logic ROMCS;
    logic Ready;
    logic nRAS;
    logic nCAS;
    logic RASEL;

    modport master (
        output BACT, AINACT, RAMCS, ROMCS,
        input  Ready, nRAS, nCAS, RASEL
    );

    modport slave (
        input  BACT, AINACT, RAMCS, ROMCS,
        output Ready, nRAS, nCAS, RASEL
    );
endinterface

// File: rtl/ram_ctl.sv
// ----------------------------------------------------------------------------
// ram_ctl -- DRAM / ROM access controller with CAS-before-RAS refresh.
//
// Sequences RAM accesses (RAS -> CAS -> HOLD -> PRE), ROM accesses with a
// programmable number of wait cycles, and periodic refresh. Refresh always
// wins arbitration in IDLE; an expiry that happens while busy is remembered
// and serviced at the next IDLE. All outputs are registered.
//
// Parameters
//   RefDiv  FCLK cycles between refresh requests (8..255)
//   ROMWS   ROM wait cycles before Ready (0..7; 0 still costs one cycle)
//
// Ports
//   FCLK    sole clock, rising edge
//   RESET   asynchronous, active-high reset
//   bus     ram_ctl_if.slave: BACT/AINACT/RAMCS/ROMCS in,
//           Ready/nRAS/nCAS/RASEL out
// ----------------------------------------------------------------------------
module ram_ctl #(
    parameter int RefDiv = 24,
    parameter int ROMWS  = 2
) (
    input  logic     FCLK,
    input  logic     RESET,
    ram_ctl_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE,
        RAS,
        CAS,
        HOLD,
        ROMW,
        ROMH,
        RCAS,
        RRAS,
        RRAS2,
        PRE
    } state_t;

    localparam logic [7:0] RefReload = 8'(RefDiv - 1);
    localparam logic [3:0] RomWait   = 4'(ROMWS);

    state_t     state;
    state_t     state_nxt;

    logic [7:0] ref_cnt;
    logic       ref_req;
    logic       ref_due;
    logic [2:0] wait_cnt;
    logic       wait_done;

    logic       ready_q;
    logic       nras_q;
    logic       ncas_q;
    logic       rasel_q;

    logic       ready_nxt;
    logic       nras_nxt;
    logic       ncas_nxt;
    logic       rasel_nxt;

    // An expiry on this very edge counts as a pending request, so an idle
    // controller starts refresh exactly RefDiv cycles after the last reload.
    assign ref_due = ref_req || (ref_cnt == 8'd0);

    // Wait counter holds the number of ROMW cycles already spent; the current
    // cycle is the last one once spent+1 reaches ROMWS (ROMWS=0 -> one cycle).
    assign wait_done = ({1'b0, wait_cnt} + 4'd1) >= RomWait;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_nxt = state;
        ready_nxt = 1'b0;
        nras_nxt  = 1'b1;
        ncas_nxt  = 1'b1;
        rasel_nxt = 1'b1;

        unique case (state)
            IDLE: begin
                if (ref_due)
                    state_nxt = RCAS;
                else if (bus.BACT && bus.ROMCS)
                    state_nxt = ROMW;
                else if (bus.BACT && bus.RAMCS)
                    state_nxt = RAS;
            end
            RAS:      state_nxt = bus.AINACT ? PRE : CAS;
            // AINACT is honoured in CAS as well so Ready can never outlive it.
            CAS,
            HOLD:     state_nxt = bus.AINACT ? PRE : HOLD;
            ROMW: begin
                if (bus.AINACT)
                    state_nxt = IDLE;
                else if (wait_done)
                    state_nxt = ROMH;
            end
            ROMH:     if (bus.AINACT) state_nxt = IDLE;
            RCAS:     state_nxt = RRAS;
            RRAS:     state_nxt = RRAS2;
            RRAS2:    state_nxt = PRE;
            PRE:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase

        // Outputs are decoded from the state being entered and then
        // registered, so they change on the same edge as the state.
        unique case (state_nxt)
            RAS: begin
                nras_nxt = 1'b0;
            end
            CAS,
            HOLD: begin
                ready_nxt = 1'b1;
                nras_nxt  = 1'b0;
                ncas_nxt  = 1'b0;
                rasel_nxt = 1'b0;
            end
            ROMH: begin
                ready_nxt = 1'b1;
            end
            RCAS: begin
                ncas_nxt = 1'b0;
            end
            RRAS,
            RRAS2: begin
                nras_nxt = 1'b0;
                ncas_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge FCLK or posedge RESET) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RESET) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            nras_q  <= 1'b1;
            ncas_q  <= 1'b1;
            rasel_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            ready_q <= ready_nxt;
            nras_q  <= nras_nxt;
            ncas_q  <= ncas_nxt;
            rasel_q <= rasel_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Refresh timer: free-running in every state. The request flag is a
    // single bit, so expiries while a request is still pending collapse.
    // ------------------------------------------------------------------
    always_ff @(posedge FCLK or posedge RESET) begin
        if (RESET) begin
            ref_cnt <= RefReload;
            ref_req <= 1'b0;
        end else begin
            if (ref_cnt == 8'd0)
                ref_cnt <= RefReload;
            else
                ref_cnt <= ref_cnt - 8'd1;

            if (state_nxt == RCAS)
                ref_req <= 1'b0;
            else if (ref_cnt == 8'd0)
                ref_req <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // ROM wait counter: cleared whenever ROMW is not being re-entered.
    // ------------------------------------------------------------------
    always_ff @(posedge FCLK or posedge RESET) begin
        if (RESET)
            wait_cnt <= 3'd0;
        else if (state == ROMW && state_nxt == ROMW)
            wait_cnt <= wait_cnt + 3'd1;
        else
            wait_cnt <= 3'd0;
    end

    assign bus.Ready = ready_q;
    assign bus.nRAS  = nras_q;
    assign bus.nCAS  = ncas_q;
    assign bus.RASEL = rasel_q;

endmodule

// File: tb/tb_ram_ctl.sv
// ----------------------------------------------------------------------------
// tb_ram_ctl -- self-checking bench for ram_ctl.
//
// A transaction-level reference model tracks what the controller should be
// presenting (free, RAM access, ROM access, refresh, precharge) plus an age
// within that activity, and derives the expected {Ready,nRAS,nCAS,RASEL}
// from it. The refresh schedule is plain arithmetic on the edge count since
// reset release. Directed steps cover the documented scenarios, followed by
// a block of randomized bus transactions.
// ----------------------------------------------------------------------------
module tb_ram_ctl;

    localparam int REF_DIV = 24;
    localparam int ROM_WS  = 2;
    localparam int WAIT_N  = (ROM_WS == 0) ? 1 : ROM_WS;
    localparam int BUDGET  = 100;

    logic FCLK  = 1'b0;
    logic RESET = 1'b0;

    ram_ctl_if bus ();

    ram_ctl #(
        .RefDiv (REF_DIV),
        .ROMWS  (ROM_WS)
    ) dut (
        .FCLK  (FCLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 FCLK = ~FCLK;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef enum {M_FREE, M_RAM, M_ROM, M_REF, M_PRECH} mode_t;

    mode_t mode    = M_FREE;
    int    age     = 0;
    int    n_edge  = 0;
    bit    pending = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [3:0] model_out();
        logic [3:0] v;
        v = 4'b0111;
        case (mode)
            M_RAM: v = (age == 0) ? 4'b0011 : 4'b1000;
            M_ROM: v = (age < WAIT_N) ? 4'b0111 : 4'b1111;
            M_REF: v = (age == 0) ? 4'b0101 : 4'b0001;
            default: v = 4'b0111;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        mode    = M_FREE;
        age     = 0;
        n_edge  = 0;
        pending = 1'b0;
    endtask

    task automatic model_edge(input bit bact, input bit ainact,
                              input bit ramcs, input bit romcs);
        bit expire;
        n_edge = n_edge + 1;
        expire = (n_edge % REF_DIV) == 0;
        if (mode == M_FREE) begin
            if (pending || expire) begin
                mode    = M_REF;
                age     = 0;
                pending = 1'b0;
            end else if (bact && romcs) begin
                mode = M_ROM;
                age  = 0;
            end else if (bact && ramcs) begin
                mode = M_RAM;
                age  = 0;
            end
        end else begin
            if (expire) pending = 1'b1;
            case (mode)
                M_RAM:   if (ainact) mode = M_PRECH; else age = 1;
                M_ROM:   if (ainact) mode = M_FREE; else if (age < WAIT_N) age++;
                M_REF:   if (age == 2) mode = M_PRECH; else age++;
                default: mode = M_FREE;
            endcase
        end
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    function automatic logic [3:0] dut_out();
        return {bus.Ready, bus.nRAS, bus.nCAS, bus.RASEL};
    endfunction

    function automatic bit dut_in_rcas();
        return (bus.nCAS == 1'b0) && (bus.nRAS == 1'b1);
    endfunction

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed {Ready,nRAS,nCAS,RASEL}=%b expected %b (edge %0d)",
                   tag, obs, exp, n_edge);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare 1 time unit later.
    task automatic step(input bit bact, input bit ainact, input bit ramcs,
                        input bit romcs, input string tag);
        bus.BACT   = bact;
        bus.AINACT = ainact;
        bus.RAMCS  = ramcs;
        bus.ROMCS  = romcs;
        @(posedge FCLK);
        model_edge(bact, ainact, ramcs, romcs);
        #1;
        check(tag, dut_out(), model_out());
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    endtask

    // Step idle until the next edge is a refresh expiry.
    task automatic align_before_expiry();
        while (((n_edge + 1) % REF_DIV) != 0) idle(1);
    endtask

    task automatic apply_reset();
        bus.BACT   = 1'b0;
        bus.AINACT = 1'b0;
        bus.RAMCS  = 1'b0;
        bus.ROMCS  = 1'b0;
        RESET      = 1'b1;
        #1;
        check("reset_async", dut_out(), 4'b0111);
        repeat (2) @(posedge FCLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    // FSB-style access: request held until the DUT raises Ready, then held
    // for 'hold' more cycles, then AINACT. 'lat' is the DUT-observed number
    // of edges from first request to Ready.
    task automatic bus_access(input bit ramcs, input bit romcs, input int hold,
                              output int lat);
        lat = 0;
        do begin
            step(1'b1, 1'b0, ramcs, romcs, "access_req");
            lat++;
        end while (bus.Ready !== 1'b1 && lat < BUDGET);
        if (lat >= BUDGET) begin
            miscompares++;
            $error("FAIL access_timeout: observed no Ready after %0d cycles expected Ready", lat);
        end
        repeat (hold) step(1'b1, 1'b0, ramcs, romcs, "access_hold");
        step(1'b1, 1'b1, ramcs, romcs, "access_end");
        step(1'b0, 1'b0, 1'b0, 1'b0, "access_idle");
    endtask

    // RAM cycle aborted by AINACT while the row strobe alone is active.
    task automatic abort_access();
        int n;
        n = 0;
        do begin
            step(1'b1, 1'b0, 1'b1, 1'b0, "abort_req");
            n++;
        end while (!(bus.nRAS === 1'b0 && bus.nCAS === 1'b1) && n < BUDGET);
        if (n >= BUDGET) begin
            miscompares++;
            $error("FAIL abort_timeout: observed no row strobe after %0d cycles expected RAS", n);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, "abort_ainact");
        step(1'b0, 1'b0, 1'b0, 1'b0, "abort_idle");
    endtask

    // Idle until the DUT starts a refresh; returns edges taken.
    task automatic edges_to_rcas(output int cnt);
        cnt = 0;
        do begin
            idle(1);
            cnt++;
        end while (!dut_in_rcas() && cnt < BUDGET);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int lat;
        int cnt;

        bus.BACT   = 1'b0;
        bus.AINACT = 1'b0;
        bus.RAMCS  = 1'b0;
        bus.ROMCS  = 1'b0;
        #2;
        apply_reset();

        // Bus active without any select: nothing happens.
        step(1'b1, 1'b0, 1'b0, 1'b0, "no_select");
        step(1'b1, 1'b0, 1'b0, 1'b0, "no_select");

        // RAM read: RAS at edge 1, CAS/Ready at edge 2, AINACT at edge 5.
        bus_access(1'b1, 1'b0, 2, lat);
        check_int("ram_latency", lat, 2);

        // ROM read with ROMWS wait cycles.
        bus_access(1'b0, 1'b1, 1, lat);
        check_int("rom_latency", lat, WAIT_N + 1);

        // Both selects: ROM wins.
        bus_access(1'b1, 1'b1, 0, lat);
        check_int("both_sel_latency", lat, WAIT_N + 1);

        // Collision: request lands on the refresh expiry edge.
        align_before_expiry();
        bus_access(1'b1, 1'b0, 1, lat);
        check_int("collision_latency", lat, 7);

        // Aborted RAM cycle.
        abort_access();
        check("abort_done", dut_out(), 4'b0111);

        // Long HOLD spanning expiries: a single refresh right after PRE.
        bus_access(1'b1, 1'b0, 40, lat);
        edges_to_rcas(cnt);
        check_int("deferred_refresh", cnt, 1);

        // Idle cadence.
        edges_to_rcas(cnt);
        edges_to_rcas(cnt);
        check_int("refresh_period", cnt, REF_DIV);

        // Reset pulsed during HOLD, checked before any clock edge.
        lat = 0;
        do begin
            step(1'b1, 1'b0, 1'b1, 1'b0, "pre_reset_req");
            lat++;
        end while (bus.Ready !== 1'b1 && lat < BUDGET);
        step(1'b1, 1'b0, 1'b1, 1'b0, "pre_reset_hold");
        #2;
        apply_reset();
        edges_to_rcas(cnt);
        check_int("first_refresh_after_reset", cnt, REF_DIV);

        // Randomized transactions.
        for (int t = 0; t < 30; t++) begin
            int kind;
            int hold;
            kind = $urandom_range(0, 4);
            hold = $urandom_range(0, 6);
            if ($urandom_range(0, 4) == 0) hold = $urandom_range(20, 35);
            case (kind)
                0: bus_access(1'b1, 1'b0, hold, lat);
                1: bus_access(1'b0, 1'b1, hold, lat);
                2: bus_access(1'b1, 1'b1, hold, lat);
                3: abort_access();
                default: begin
                    repeat (hold + 1)
                        step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, "rand_gap");
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_ctl.md
RAM_CTL -- requirements
Module: ram_ctl

Interface
REQ-001 SHALL have parameter RefDiv, default 24: FCLK cycles between refresh requests (legal 8..255).
REQ-002 SHALL have parameter ROMWS, default 2: ROM wait cycles before Ready (legal 0..7).
REQ-003 SHALL have port FCLK  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port BACT  in  1  bus cycle active, from the FSB stage.
REQ-006 SHALL have port AINACT  in  1  end-of-cycle strobe, from the FSB stage.
REQ-007 SHALL have port RAMCS  in  1  decoded RAM select, stable while BACT=1.
REQ-008 SHALL have port ROMCS  in  1  decoded ROM select, stable while BACT=1.
REQ-009 SHALL have port Ready  out  1  access may complete; consumed by the FSB stage for DTACK.
REQ-010 SHALL have port nRAS  out  1  DRAM row strobe, active low.
REQ-011 SHALL have port nCAS  out  1  DRAM column strobe, active low.
REQ-012 SHALL have port RASEL  out  1  address mux select: 1=row, 0=column.

Function
REQ-013 SHALL register all outputs; no combinational input-to-output paths.
REQ-014 SHALL implement states IDLE, RAS, CAS, HOLD, ROMW, ROMH, RCAS, RRAS, RRAS2, PRE.
REQ-015 SHALL run a refresh down-counter: on reaching 0, reload RefDiv-1 and set RefReq; RefReq remains set (no second request queued) until RCAS is entered, then clears.
REQ-016 IDLE: RefReq=1 -> RCAS, regardless of BACT, RAMCS, ROMCS (refresh has priority; access waits with Ready=0).
REQ-017 IDLE, RefReq=0, BACT=1, ROMCS=1 -> ROMW (ROMCS wins if RAMCS also 1).
REQ-018 IDLE, RefReq=0, BACT=1, RAMCS=1, ROMCS=0 -> RAS.
REQ-019 IDLE with BACT=0 or no select: remain IDLE; Ready=0, nRAS=nCAS=1, RASEL=1.
REQ-020 RAS: nRAS=0, RASEL=1, one cycle -> CAS; AINACT=1 in RAS -> PRE with Ready=0.
REQ-021 CAS: nRAS=0, nCAS=0, RASEL=0, Ready=1 -> HOLD.
REQ-022 HOLD: outputs as CAS; AINACT=1 -> PRE.
REQ-023 ROMW: wait-counter counts ROMWS cycles, Ready=0, then -> ROMH; ROMWS=0 gives one ROMW cycle.
REQ-024 ROMH: Ready=1 until AINACT=1, then -> IDLE with Ready=0; AINACT in ROMW -> IDLE.
REQ-025 Refresh (CAS-before-RAS): RCAS nCAS=0 nRAS=1; RRAS and RRAS2 nCAS=0 nRAS=0; then PRE.
REQ-026 PRE: nRAS=nCAS=1, RASEL=1, Ready=0, exactly one cycle -> IDLE.
REQ-027 Ready SHALL deassert on the edge on which AINACT is sampled 1; never high outside CAS/HOLD/ROMH.
REQ-028 Refresh counter SHALL keep counting in every state; an expiry during an access is serviced at the next IDLE.
REQ-029 nRAS SHALL never be low for more than 2 consecutive cycles during refresh.

Reset
REQ-030 RESET=1 SHALL immediately force IDLE, Ready=0, nRAS=1, nCAS=1, RASEL=1, RefReq=0, counter=RefDiv-1, wait-counter=0.
REQ-031 RESET asserted mid-access or mid-refresh SHALL abort it with no further strobe activity; first refresh request comes RefDiv cycles after release.

Verification
REQ-032 RAM read, RefReq=0: BACT,RAMCS=1 at edge 0 -> RAS edge 1, CAS/Ready=1 edge 2; AINACT edge 5 -> PRE, Ready=0, nRAS=nCAS=1; IDLE edge 6.
REQ-033 ROM read, ROMWS=2: BACT,ROMCS=1 -> Ready=1 after ROMW 2 cycles; AINACT -> Ready=0 same edge, IDLE.
REQ-034 Collision: RefReq=1 and BACT,RAMCS=1 same cycle -> RCAS,RRAS,RRAS2,PRE (4 cycles, Ready=0) then RAS; access completes.
REQ-035 Refresh cadence, idle bus, RefDiv=24: refresh sequences start every 24 cycles; expiry during long HOLD defers refresh to after PRE, no lost or doubled refresh.
REQ-036 RESET pulsed during HOLD: all strobes high and Ready=0 without clock; first RCAS 24 cycles after release.
REQ-037 AINACT during RAS (aborted cycle): -> PRE, Ready never asserted, nCAS never low.
